lfst: RTL and testbench

LFST -- requirements
Module: lfst

---
 rtl/lfst_pkg.sv | 21 ++
 rtl/lfst_grp_bypass.sv | 45 ++++
 rtl/lfst.sv | 175 +++++++++++++++++
 tb/tb_lfst.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfst_pkg.sv
// ============================================================================
// lfst_pkg : shared sizing constants and entry type for the LFST.
// Rev 1.0  : initial release.
// ============================================================================
`default_nettype none

package lfst_pkg;

  localparam int LFST_DEPTH = 128;
  localparam int SSID_W     = 7;
  localparam int TAG_W      = 7;
  localparam int SLOTS      = 4;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } lfst_entry_t;

endpackage

`default_nettype wire

// File: rtl/lfst_grp_bypass.sv
// ============================================================================
// lfst_grp_bypass : intra-group store bypass and per-SSID youngest-store pick.
// Rev 1.0         : initial release.
// ============================================================================
`default_nettype none

module lfst_grp_bypass #(
  parameter int TAG_W = lfst_pkg::TAG_W
) (
  input  logic [3:0]                         active,
  input  logic [3:0]                         is_st,
  input  logic [3:0][lfst_pkg::SSID_W-1:0]   ssid,
  input  logic [3:0][TAG_W-1:0]              tag,
  output logic [3:0]                         byp_hit,
  output logic [3:0][TAG_W-1:0]              byp_tag,
  output logic [3:0]                         wr_en
);

  import lfst_pkg::*;

  always_comb begin
    byp_hit = '0;
    byp_tag = '0;
    wr_en   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      // Ascending scan: the last match is the youngest older store.
      for (int j = 0; j < i; j++) begin
        if (active[j] && is_st[j] && (ssid[j] == ssid[i])) begin
          byp_hit[i] = 1'b1;
          byp_tag[i] = tag[j];
        end
      end
      // Only the youngest store per SSID writes, so writes never collide.
      wr_en[i] = active[i] && is_st[i];
      for (int j = i + 1; j < SLOTS; j++) begin
        if (active[j] && is_st[j] && (ssid[j] == ssid[i])) begin
          wr_en[i] = 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfst.sv
// ============================================================================
// lfst : last-fetched-store table, 4-wide rename lookup; LFST_STORE_CHAIN_EN
//        enables store-to-store dependences.  Rev 1.0 : initial release.
// ============================================================================
`default_nettype none

module lfst #(
  parameter int LFST_DEPTH = lfst_pkg::LFST_DEPTH,
  parameter int TAG_W      = lfst_pkg::TAG_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          inst0_vld_i,
  input  logic [lfst_pkg::SSID_W-1:0]   inst0_ssid_i,
  input  logic                          inst0_ssid_vld_i,
  input  logic                          inst0_is_st_i,
  input  logic [TAG_W-1:0]              inst0_tag_i,
  input  logic                          inst1_vld_i,
  input  logic [lfst_pkg::SSID_W-1:0]   inst1_ssid_i,
  input  logic                          inst1_ssid_vld_i,
  input  logic                          inst1_is_st_i,
  input  logic [TAG_W-1:0]              inst1_tag_i,
  input  logic                          inst2_vld_i,
  input  logic [lfst_pkg::SSID_W-1:0]   inst2_ssid_i,
  input  logic                          inst2_ssid_vld_i,
  input  logic                          inst2_is_st_i,
  input  logic [TAG_W-1:0]              inst2_tag_i,
  input  logic                          inst3_vld_i,
  input  logic [lfst_pkg::SSID_W-1:0]   inst3_ssid_i,
  input  logic                          inst3_ssid_vld_i,
  input  logic                          inst3_is_st_i,
  input  logic [TAG_W-1:0]              inst3_tag_i,
  input  logic                          rename_stall_i,
  input  logic                          st_iss_vld_i,
  input  logic [lfst_pkg::SSID_W-1:0]   st_iss_ssid_i,
  input  logic [TAG_W-1:0]              st_iss_tag_i,
  input  logic                          flush_i,
  output logic                          inst0_dep_vld_o,
  output logic [TAG_W-1:0]              inst0_dep_tag_o,
  output logic                          inst1_dep_vld_o,
  output logic [TAG_W-1:0]              inst1_dep_tag_o,
  output logic                          inst2_dep_vld_o,
  output logic [TAG_W-1:0]              inst2_dep_tag_o,
  output logic                          inst3_dep_vld_o,
  output logic [TAG_W-1:0]              inst3_dep_tag_o
);

  import lfst_pkg::*;

`ifdef LFST_STORE_CHAIN_EN
  localparam bit STORE_CHAIN = 1'b1;
`else
  localparam bit STORE_CHAIN = 1'b0;
`endif

  logic [3:0]             slot_vld;
  logic [3:0]             slot_svld;
  logic [3:0]             slot_st;
  logic [3:0]             slot_act;
  logic [3:0][SSID_W-1:0] slot_ssid;
  logic [3:0][TAG_W-1:0]  slot_tag;

  assign slot_vld  = {inst3_vld_i, inst2_vld_i, inst1_vld_i, inst0_vld_i};
  assign slot_svld = {inst3_ssid_vld_i, inst2_ssid_vld_i, inst1_ssid_vld_i, inst0_ssid_vld_i};
  assign slot_st   = {inst3_is_st_i, inst2_is_st_i, inst1_is_st_i, inst0_is_st_i};
  assign slot_ssid = {inst3_ssid_i, inst2_ssid_i, inst1_ssid_i, inst0_ssid_i};
  assign slot_tag  = {inst3_tag_i, inst2_tag_i, inst1_tag_i, inst0_tag_i};
  assign slot_act  = slot_vld & slot_svld;

  logic [LFST_DEPTH-1:0]  ent_valid;
  logic [TAG_W-1:0]       ent_tag [LFST_DEPTH];

  logic [3:0]             byp_hit;
  logic [3:0][TAG_W-1:0]  byp_tag;
  logic [3:0]             wr_en;

  lfst_grp_bypass #(
    .TAG_W   (TAG_W)
  ) u_grp_bypass (
    .active  (slot_act),
    .is_st   (slot_st),
    .ssid    (slot_ssid),
    .tag     (slot_tag),
    .byp_hit (byp_hit),
    .byp_tag (byp_tag),
    .wr_en   (wr_en)
  );

  logic inv_hit;
  assign inv_hit = st_iss_vld_i && ent_valid[st_iss_ssid_i]
                   && (ent_tag[st_iss_ssid_i] == st_iss_tag_i);

  logic [3:0]             tbl_live;
  logic [3:0]             want_dep;
  logic [3:0]             nxt_vld;
  logic [3:0][TAG_W-1:0]  nxt_tag;

  // An entry being invalidated this cycle is treated as already gone.
  always_comb begin
    tbl_live = '0;
    want_dep = '0;
    nxt_vld  = '0;
    nxt_tag  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      tbl_live[i] = ent_valid[slot_ssid[i]]
                    && !(st_iss_vld_i && (st_iss_ssid_i == slot_ssid[i])
                         && (st_iss_tag_i == ent_tag[slot_ssid[i]]));
      want_dep[i] = slot_act[i] && (!slot_st[i] || STORE_CHAIN);
      nxt_vld[i]  = want_dep[i] && (byp_hit[i] || tbl_live[i]);
      if (want_dep[i] && byp_hit[i]) begin
        nxt_tag[i] = byp_tag[i];
      end else if (want_dep[i] && tbl_live[i]) begin
        nxt_tag[i] = ent_tag[slot_ssid[i]];
      end
    end
  end

  // Write is ordered after invalidate so a concurrent write wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_valid <= '0;
    end else if (flush_i) begin
      ent_valid <= '0;
    end else begin
      if (inv_hit) begin
        ent_valid[st_iss_ssid_i] <= 1'b0;
      end
      if (!rename_stall_i) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (wr_en[i]) begin
            ent_valid[slot_ssid[i]] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!flush_i && !rename_stall_i) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (wr_en[i]) begin
          ent_tag[slot_ssid[i]] <= slot_tag[i];
        end
      end
    end
  end

  logic [3:0]             dep_vld;
  logic [3:0][TAG_W-1:0]  dep_tag;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dep_vld <= '0;
      dep_tag <= '0;
    end else if (flush_i) begin
      dep_vld <= '0;
      dep_tag <= '0;
    end else if (!rename_stall_i) begin
      dep_vld <= nxt_vld;
      dep_tag <= nxt_tag;
    end
  end

  assign inst0_dep_vld_o = dep_vld[0];
  assign inst1_dep_vld_o = dep_vld[1];
  assign inst2_dep_vld_o = dep_vld[2];
  assign inst3_dep_vld_o = dep_vld[3];
  assign inst0_dep_tag_o = dep_tag[0];
  assign inst1_dep_tag_o = dep_tag[1];
  assign inst2_dep_tag_o = dep_tag[2];
  assign inst3_dep_tag_o = dep_tag[3];

endmodule

`default_nettype wire

// File: tb/tb_lfst.sv
// ============================================================================
// tb_lfst : scoreboard bench for lfst against a table-level reference model.
// Rev 1.0 : initial release.
// ============================================================================
`default_nettype none

module tb_lfst;

`ifdef LFST_STORE_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]      vld;
    logic [3:0][6:0] tag;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] vld, svld, is_st;
  logic [6:0] ssid [4];
  logic [6:0] tag  [4];
  logic       stall, iss_vld, flush;
  logic [6:0] iss_ssid, iss_tag;
  logic [3:0] dep_vld;
  logic [6:0] dep_tag [4];

  int errors = 0;
  int checks = 0;

  exp_t exp_q [$];
  exp_t last_exp;
  bit   m_valid [128];
  logic [6:0] m_tag [128];

  always #5 clock = ~clock;

  lfst dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .inst0_vld_i      (vld[0]),  .inst0_ssid_i (ssid[0]), .inst0_ssid_vld_i (svld[0]),
    .inst0_is_st_i    (is_st[0]), .inst0_tag_i (tag[0]),
    .inst1_vld_i      (vld[1]),  .inst1_ssid_i (ssid[1]), .inst1_ssid_vld_i (svld[1]),
    .inst1_is_st_i    (is_st[1]), .inst1_tag_i (tag[1]),
    .inst2_vld_i      (vld[2]),  .inst2_ssid_i (ssid[2]), .inst2_ssid_vld_i (svld[2]),
    .inst2_is_st_i    (is_st[2]), .inst2_tag_i (tag[2]),
    .inst3_vld_i      (vld[3]),  .inst3_ssid_i (ssid[3]), .inst3_ssid_vld_i (svld[3]),
    .inst3_is_st_i    (is_st[3]), .inst3_tag_i (tag[3]),
    .rename_stall_i   (stall),
    .st_iss_vld_i     (iss_vld),
    .st_iss_ssid_i    (iss_ssid),
    .st_iss_tag_i     (iss_tag),
    .flush_i          (flush),
    .inst0_dep_vld_o  (dep_vld[0]), .inst0_dep_tag_o (dep_tag[0]),
    .inst1_dep_vld_o  (dep_vld[1]), .inst1_dep_tag_o (dep_tag[1]),
    .inst2_dep_vld_o  (dep_vld[2]), .inst2_dep_tag_o (dep_tag[2]),
    .inst3_dep_vld_o  (dep_vld[3]), .inst3_dep_tag_o (dep_tag[3])
  );

  task automatic clear_inputs();
    vld = '0; svld = '0; is_st = '0;
    for (int i = 0; i < 4; i++) begin
      ssid[i] = '0;
      tag[i]  = '0;
    end
    stall = 1'b0; iss_vld = 1'b0; flush = 1'b0;
    iss_ssid = '0; iss_tag = '0;
  endtask

  task automatic set_slot(input int i, input bit st, input int s, input int t);
    vld[i] = 1'b1; svld[i] = 1'b1; is_st[i] = st;
    ssid[i] = 7'(s); tag[i] = 7'(t);
  endtask

  task automatic set_issue(input int s, input int t);
    iss_vld = 1'b1; iss_ssid = 7'(s); iss_tag = 7'(t);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 128; k++) m_valid[k] = 1'b0;
    last_exp = '0;
  endtask

  // Reference model: compute this cycle's expected registered outputs from
  // the table as it stands, then apply flush / invalidate / store writes.
  task automatic issue();
    exp_t e;
    logic [3:0] act;
    bit found;
    act = vld & svld;
    e = '0;
    if (flush) begin
      e = '0;
    end else if (stall) begin
      e = last_exp;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (act[i] && (!is_st[i] || CHAIN)) begin
          found = 1'b0;
          for (int j = i - 1; j >= 0; j--) begin
            if (!found && act[j] && is_st[j] && ssid[j] == ssid[i]) begin
              found = 1'b1;
              e.vld[i] = 1'b1;
              e.tag[i] = tag[j];
            end
          end
          if (!found && m_valid[ssid[i]]
              && !(iss_vld && iss_ssid == ssid[i] && iss_tag == m_tag[ssid[i]])) begin
            e.vld[i] = 1'b1;
            e.tag[i] = m_tag[ssid[i]];
          end
        end
      end
    end
    last_exp = e;
    exp_q.push_back(e);
    if (flush) begin
      for (int k = 0; k < 128; k++) m_valid[k] = 1'b0;
    end else begin
      if (iss_vld && m_valid[iss_ssid] && m_tag[iss_ssid] == iss_tag)
        m_valid[iss_ssid] = 1'b0;
      if (!stall) begin
        for (int i = 0; i < 4; i++) begin
          if (act[i] && is_st[i]) begin
            m_valid[ssid[i]] = 1'b1;
            m_tag[ssid[i]]   = tag[i];
          end
        end
      end
    end
  endtask

  // Monitor: one registered result per clock, compared against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (dep_vld[i] !== e.vld[i]) begin
            errors++;
            $display("FAIL dep_vld slot%0d t=%0t: got %0b want %0b", i, $time, dep_vld[i], e.vld[i]);
          end
          if (e.vld[i]) begin
            checks++;
            if (dep_tag[i] !== e.tag[i]) begin
              errors++;
              $display("FAIL dep_tag slot%0d t=%0t: got %h want %h", i, $time, dep_tag[i], e.tag[i]);
            end
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dep_vld[i] !== 1'b0 || dep_tag[i] !== 7'h00) begin
        errors++;
        $display("FAIL %s slot%0d: got vld=%0b tag=%h want vld=0 tag=00", name, i, dep_vld[i], dep_tag[i]);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    clear_inputs();
  endtask

  initial begin
    int s;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Directed scenarios
    cyc(); set_slot(0, 0, 5, 0);                            issue();
    cyc(); set_slot(0, 1, 5, 'h12);                         issue();
    cyc(); set_slot(0, 0, 5, 0);                            issue();
    cyc(); set_slot(0, 1, 3, 'h20); set_slot(2, 1, 3, 'h22);
           set_slot(3, 0, 3, 0);                            issue();
    cyc(); set_slot(1, 0, 3, 0);                            issue();
    cyc(); set_issue(5, 'h11);                              issue();
    cyc(); set_slot(0, 0, 5, 0);                            issue();
    cyc(); set_issue(5, 'h12); set_slot(2, 0, 5, 0);        issue();
    cyc(); set_slot(0, 0, 5, 0);                            issue();
    cyc(); set_slot(0, 1, 7, 'h30);                         issue();
    cyc(); set_issue(7, 'h30); set_slot(0, 1, 7, 'h31);     issue();
    cyc(); set_slot(3, 0, 7, 0);                            issue();
    cyc(); set_slot(0, 1, 9, 'h40); flush = 1'b1;           issue();
    cyc(); set_slot(0, 0, 9, 0);                            issue();
    cyc(); set_slot(0, 1, 4, 'h01); set_slot(1, 1, 4, 'h02);
           set_slot(2, 0, 4, 0);                            issue();
    cyc(); set_slot(0, 1, 6, 'h05); stall = 1'b1;           issue();
    cyc(); set_slot(0, 0, 6, 0); set_slot(1, 0, 4, 0);      issue();

    // Randomized traffic with a small SSID range to force collisions
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
      end
      cyc();
      for (int i = 0; i < 4; i++) begin
        vld[i]   = ($urandom_range(0, 9) < 7);
        svld[i]  = ($urandom_range(0, 9) < 8);
        is_st[i] = $urandom_range(0, 1);
        ssid[i]  = 7'($urandom_range(0, 7));
        tag[i]   = 7'($urandom);
      end
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 4) begin
        s = $urandom_range(0, 7);
        set_issue(s, $urandom_range(0, 1) ? int'(m_tag[s]) : int'($urandom_range(0, 127)));
      end
      issue();
    end

    @(negedge clock);
    clear_inputs();
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
